// File: rtl/rt_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package : rt_pipe_pkg
// Shared per-stage control record and default depths for the pipe scoreboard.
// Rev     : 1.0
// ============================================================================
package rt_pipe_pkg;

  localparam int c_DEPTH      = 5;
  localparam int c_IO_DEPTH   = 7;
  localparam int c_BR_DEPTH   = 4;
  localparam int c_REG_AW     = 3;
  // Destination field is sized for the widest supported register file.
  localparam int c_REG_AW_MAX = 8;

  typedef struct packed {
    logic                    v;
    logic                    wr_en;
    logic [c_REG_AW_MAX-1:0] wr;
    logic                    io_wr;
    logic                    br;
  } stage_ctl_t;

  localparam int         c_STAGE_W = $bits(stage_ctl_t);
  localparam stage_ctl_t c_BUBBLE  = '0;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module : pipe_stage_reg
// One pipeline stage control register with freeze, squash and bubble inputs.
// Rev    : 1.0
// ============================================================================
module pipe_stage_reg
  import rt_pipe_pkg::*;
(
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 hold_i,
  input  logic                 kill_i,
  input  logic                 bubble_i,
  input  logic [c_STAGE_W-1:0] stage_i,
  output logic [c_STAGE_W-1:0] stage_o
);

  stage_ctl_t stage_d;
  stage_ctl_t stage_q;

  always_comb begin
    stage_d = stage_ctl_t'(stage_i);
    if (bubble_i) begin
      stage_d = c_BUBBLE;
    end
    // A squashed stage only loses its valid bit; the other fields are ignored.
    if (kill_i) begin
      stage_d.v = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      stage_q <= c_BUBBLE;
    end else if (!hold_i) begin
      stage_q <= stage_d;
    end
  end

  assign stage_o = stage_q;

endmodule
`default_nettype wire

// File: rtl/pipe_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : pipe_scoreboard
// Tracks in-flight control per stage; drives hazard, freeze, flush, core reset.
// Rev    : 1.0
// ============================================================================
module pipe_scoreboard
  import rt_pipe_pkg::*;
#(
  parameter int DEPTH    = c_DEPTH,
  parameter int IO_DEPTH = c_IO_DEPTH,
  parameter int BR_DEPTH = c_BR_DEPTH,
  parameter int REG_AW   = c_REG_AW
) (
  input  logic                          clk,
  input  logic                          n_reset,
  input  logic                          issue_valid,
  input  logic                          issue_rd_en,
  input  logic [REG_AW-1:0]             issue_rd,
  input  logic                          issue_wr_en,
  input  logic [REG_AW-1:0]             issue_wr,
  input  logic                          issue_io_rd,
  input  logic                          issue_io_wr,
  input  logic                          issue_branch,
  input  logic                          br_taken,
  input  logic                          hold,
  input  logic                          halt,
  output logic                          hazard,
  output logic                          freeze,
  output logic                          flush,
  output logic                          core_rst,
  output logic [$clog2(IO_DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(IO_DEPTH+1);

  logic [c_STAGE_W-1:0] stage_d [1:IO_DEPTH];
  logic [c_STAGE_W-1:0] stage_q [1:IO_DEPTH];
  logic                 bubble  [1:IO_DEPTH];
  logic                 kill    [1:IO_DEPTH];
  stage_ctl_t           st      [1:IO_DEPTH];
  stage_ctl_t           issue_ctl;
  logic                 raw_hit;
  logic                 io_hit;
  logic                 br_hit;
  logic                 accept;
  logic [OCC_W-1:0]     occ_sum;
  logic                 unused_bits;
  logic                 rst_pend_q;
  logic                 core_rst_q;

  always_comb begin
    for (int k = 1; k <= IO_DEPTH; k++) begin
      st[k] = stage_ctl_t'(stage_q[k]);
    end
  end

  // Match at stage DEPTH still blocks: the register file has no write-through.
  always_comb begin
    raw_hit     = 1'b0;
    io_hit      = 1'b0;
    br_hit      = 1'b0;
    occ_sum     = '0;
    unused_bits = 1'b0;
    for (int k = 1; k <= IO_DEPTH; k++) begin
      if (k <= DEPTH && issue_rd_en && st[k].v && st[k].wr_en &&
          (st[k].wr[REG_AW-1:0] == issue_rd)) begin
        raw_hit = 1'b1;
      end
      if (issue_io_rd && st[k].v && st[k].io_wr) begin
        io_hit = 1'b1;
      end
      if (k < BR_DEPTH && st[k].v && st[k].br) begin
        br_hit = 1'b1;
      end
      occ_sum     = occ_sum + OCC_W'(st[k].v);
      unused_bits = unused_bits ^ (^stage_q[k]);
    end
  end

  assign hazard = halt | raw_hit | io_hit | br_hit;
  assign flush  = st[BR_DEPTH].v & st[BR_DEPTH].br & br_taken & ~hold;
  assign accept = issue_valid & ~hazard & ~flush & ~hold;
  assign freeze = hold;

  always_comb begin
    issue_ctl                = c_BUBBLE;
    issue_ctl.v              = 1'b1;
    issue_ctl.wr_en          = issue_wr_en;
    issue_ctl.wr[REG_AW-1:0] = issue_wr;
    issue_ctl.io_wr          = issue_io_wr;
    issue_ctl.br             = issue_branch;
  end

  for (genvar k = 1; k <= IO_DEPTH; k++) begin : g_stage
    if (k == 1) begin : g_head
      assign stage_d[k] = issue_ctl;
      assign bubble[k]  = ~accept;
      assign kill[k]    = 1'b0;
    end else begin : g_body
      assign stage_d[k] = stage_q[k-1];
      assign bubble[k]  = 1'b0;
      assign kill[k]    = (k <= BR_DEPTH) ? flush : 1'b0;
    end

    pipe_stage_reg u_stage (
      .clk      (clk),
      .n_reset  (n_reset),
      .hold_i   (hold),
      .kill_i   (kill[k]),
      .bubble_i (bubble[k]),
      .stage_i  (stage_d[k]),
      .stage_o  (stage_q[k])
    );
  end

  // Popcount of the stage valid registers, so it only moves at clock edges.
  assign occupancy = occ_sum;

  // Core reset is held for one further unfrozen edge after n_reset rises.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      rst_pend_q <= 1'b1;
      core_rst_q <= 1'b1;
    end else if (!hold) begin
      rst_pend_q <= 1'b0;
      core_rst_q <= rst_pend_q;
    end
  end

  assign core_rst = core_rst_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : tb_pipe_scoreboard
// Directed self-checking bench for pipe_scoreboard (default depths 5/7/4).
// Rev    : 1.0
// ============================================================================
module tb_pipe_scoreboard;

  logic       clk;
  logic       n_reset;
  logic       issue_valid;
  logic       issue_rd_en;
  logic [2:0] issue_rd;
  logic       issue_wr_en;
  logic [2:0] issue_wr;
  logic       issue_io_rd;
  logic       issue_io_wr;
  logic       issue_branch;
  logic       br_taken;
  logic       hold;
  logic       halt;
  logic       hazard;
  logic       freeze;
  logic       flush;
  logic       core_rst;
  logic [2:0] occupancy;

  int n_checks;
  int n_fail;

  pipe_scoreboard u_dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .issue_valid  (issue_valid),
    .issue_rd_en  (issue_rd_en),
    .issue_rd     (issue_rd),
    .issue_wr_en  (issue_wr_en),
    .issue_wr     (issue_wr),
    .issue_io_rd  (issue_io_rd),
    .issue_io_wr  (issue_io_wr),
    .issue_branch (issue_branch),
    .br_taken     (br_taken),
    .hold         (hold),
    .halt         (halt),
    .hazard       (hazard),
    .freeze       (freeze),
    .flush        (flush),
    .core_rst     (core_rst),
    .occupancy    (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rd_en, input logic [2:0] rd,
                       input logic wr_en, input logic [2:0] wr,
                       input logic io_rd, input logic io_wr, input logic br);
    issue_valid  = v;
    issue_rd_en  = rd_en;
    issue_rd     = rd;
    issue_wr_en  = wr_en;
    issue_wr     = wr;
    issue_io_rd  = io_rd;
    issue_io_wr  = io_wr;
    issue_branch = br;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic nop();
    drive(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_reset  = 1'b0;
    hold     = 1'b0;
    halt     = 1'b0;
    br_taken = 1'b0;
    idle();

    // Reset values and core reset stretch
    step();
    step();
    check("rst_occ", 32'(occupancy), 0);
    check("rst_core", 32'(core_rst), 1);
    check("rst_haz", 32'(hazard), 0);
    check("rst_flush", 32'(flush), 0);
    check("rst_freeze", 32'(freeze), 0);
    n_reset = 1'b1;
    step();
    check("core_rst_e1", 32'(core_rst), 1);
    step();
    check("core_rst_e2", 32'(core_rst), 0);

    // RAW: four fillers, write r3 at t0, read r3 at t1
    for (int i = 0; i < 4; i++) begin
      nop();
      step();
    end
    drive(1'b1, 1'b0, 3'd0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    #1;
    check("raw_prod_acc", 32'(hazard), 0);
    step();
    drive(1'b1, 1'b1, 3'd3, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int t = 1; t <= 5; t++) begin
      #1;
      check("raw_stall", 32'(hazard), 1);
      if (t == 1) check("raw_occ_peak", 32'(occupancy), 5);
      if (t == 4) check("raw_occ_t4", 32'(occupancy), 4);
      step();
    end
    #1;
    check("raw_accept", 32'(hazard), 0);
    check("raw_occ_t6", 32'(occupancy), 2);
    step();
    idle();
    check("raw_occ_t7", 32'(occupancy), 2);
    repeat (8) step();

    // IO write at t0, IO read (also reading unrelated r5) from t1
    drive(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    #1;
    check("io_wr_acc", 32'(hazard), 0);
    step();
    drive(1'b1, 1'b1, 3'd5, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    for (int t = 1; t <= 7; t++) begin
      #1;
      check("io_stall", 32'(hazard), 1);
      step();
    end
    #1;
    check("io_accept", 32'(hazard), 0);
    step();
    idle();
    repeat (8) step();

    // Taken branch; one held cycle at resolve gates the flush
    drive(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    #1;
    check("br_acc", 32'(hazard), 0);
    step();
    nop();
    for (int t = 1; t <= 3; t++) begin
      #1;
      check("br_stall", 32'(hazard), 1);
      check("br_noflush", 32'(flush), 0);
      step();
    end
    hold = 1'b1;
    br_taken = 1'b1;
    #1;
    check("br_flush_held", 32'(flush), 0);
    check("br_freeze", 32'(freeze), 1);
    step();
    hold = 1'b0;
    #1;
    check("br_flush", 32'(flush), 1);
    step();
    br_taken = 1'b0;
    #1;
    check("br_flush_once", 32'(flush), 0);
    check("br_after_acc", 32'(hazard), 0);
    check("br_occ_sq", 32'(occupancy), 1);
    step();
    idle();
    check("br_occ_next", 32'(occupancy), 2);
    repeat (8) step();

    // Not-taken branch advances; issue accepted once it reaches resolve stage
    drive(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    step();
    nop();
    repeat (3) step();
    #1;
    check("brnt_haz", 32'(hazard), 0);
    check("brnt_flush", 32'(flush), 0);
    step();
    idle();
    check("brnt_occ", 32'(occupancy), 2);
    repeat (8) step();

    // Hold for 3 cycles while the producer sits at stage 2
    drive(1'b1, 1'b0, 3'd0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b1, 3'd3, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step();
    hold = 1'b1;
    for (int t = 2; t <= 4; t++) begin
      #1;
      check("hold_haz", 32'(hazard), 1);
      check("hold_freeze", 32'(freeze), 1);
      check("hold_occ", 32'(occupancy), 1);
      step();
    end
    hold = 1'b0;
    for (int t = 5; t <= 8; t++) begin
      #1;
      check("hold_stall", 32'(hazard), 1);
      step();
    end
    #1;
    check("hold_accept", 32'(hazard), 0);
    step();
    idle();
    repeat (8) step();

    // Halt on an empty pipe
    halt = 1'b1;
    nop();
    #1;
    check("halt_haz", 32'(hazard), 1);
    step();
    check("halt_noacc", 32'(occupancy), 0);
    halt = 1'b0;
    #1;
    check("halt_rel", 32'(hazard), 0);
    step();
    idle();
    check("halt_acc", 32'(occupancy), 1);
    repeat (8) step();

    // Reset mid-operation with six stages valid, under hold
    nop();
    repeat (6) step();
    idle();
    check("pre_rst_occ", 32'(occupancy), 6);
    n_reset = 1'b0;
    hold = 1'b1;
    step();
    check("mrst_occ", 32'(occupancy), 0);
    check("mrst_haz", 32'(hazard), 0);
    check("mrst_core", 32'(core_rst), 1);
    check("mrst_freeze", 32'(freeze), 1);
    step();
    n_reset = 1'b1;
    hold = 1'b0;
    step();
    check("mrst_core_e1", 32'(core_rst), 1);
    step();
    check("mrst_core_e2", 32'(core_rst), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_scoreboard.md
# pipe_scoreboard

Parametrised pipeline control tracker for the RIPTIDE core family. It replaces hand-unrolled per-stage control chains (write-enable, destination, IO-write, branch flags) with DEPTH-configurable shift pipes. It generates bubble-insert, freeze and flush controls from register RAW, IO write-before-read and in-flight-branch conditions. It sits between the decode unit and the datapath stage registers, and also produces the stretched core reset.

## Interface
- DEPTH, 5: stage index at which the register file is written; pipe length for register tracking.
- IO_DEPTH, 7: stage index at which an IO write completes; pipe length for IO tracking (IO_DEPTH >= DEPTH).
- BR_DEPTH, 4: stage index at which branches resolve (2 <= BR_DEPTH <= DEPTH).
- REG_AW, 3: register address width.
- clk  in  1  single clock; all state updates on rising edge.
- n_reset  in  1  synchronous, active-low reset.
- issue_valid  in  1  decode presents an instruction.
- issue_rd_en  in  1  instruction reads register issue_rd.
- issue_rd  in  REG_AW  source register.
- issue_wr_en  in  1  instruction writes issue_wr.
- issue_wr  in  REG_AW  destination register.
- issue_io_rd  in  1  instruction performs an IO read.
- issue_io_wr  in  1  instruction performs an IO write.
- issue_branch  in  1  instruction is NZT/XEC/JMP-class with late resolve.
- br_taken  in  1  valid when the branch is at stage BR_DEPTH; 1 = redirect.
- hold  in  1  external freeze (cache miss).
- halt  in  1  stop issuing.
- hazard  out  1  combinational; current issue is not accepted and a bubble enters stage 1.
- freeze  out  1  equals hold; all stage registers keep their value.
- flush  out  1  combinational; stages 1..BR_DEPTH-1 are squashed this cycle.
- core_rst  out  1  registered stretched reset.
- occupancy  out  $clog2(IO_DEPTH+1)  count of valid stages 1..IO_DEPTH.

## Operation
- Per stage k (1..IO_DEPTH) hold: v[k], wr_en[k], wr[k], io_wr[k], br[k]. Register tracking (wr_en, wr) is used only for k <= DEPTH.
- Accept = issue_valid & ~hazard & ~flush & ~hold. When accepted, stage 1 loads the issue fields. Otherwise stage 1 loads all zeros (bubble).
- RAW condition: issue_rd_en, and some k in 1..DEPTH has v[k] & wr_en[k] & wr[k]==issue_rd. The write at stage DEPTH lands at the end of that cycle, and the register file has no write-through, so a match at stage k = DEPTH still counts.
- IO condition: issue_io_rd, and some k in 1..IO_DEPTH has v[k] & io_wr[k].
- Branch condition: some k in 1..BR_DEPTH-1 has v[k] & br[k].
- hazard = halt | RAW | IO | branch. hazard is evaluated even when issue_valid=0.
- flush = v[BR_DEPTH] & br[BR_DEPTH] & br_taken & ~hold. On flush, v is cleared for stages 1..BR_DEPTH, and stages BR_DEPTH+1.. shift normally.
- Priority: reset > hold > flush > hazard > accept.
- occupancy = popcount(v[1..IO_DEPTH]), registered along with the stages.

## Timing
- Stage advance: one stage per non-held cycle. An instruction accepted in cycle t is at stage k in cycle t+k (with no hold).
- RAW penalty: a dependent instruction issuing immediately after its producer stalls DEPTH cycles. It is accepted in the cycle the producer has left stage DEPTH.
- hold: all registers, occupancy and core_rst-stretch counter are frozen. hazard and flush remain combinational from frozen state, but flush is gated to 0.
- Reset (n_reset low at an edge) clears every v, wr_en, io_wr, br and occupancy, and sets core_rst=1. core_rst stays 1 for exactly one edge after n_reset is seen high, then drops. Reset takes effect mid-operation regardless of hold.
- Reset values: hazard=halt (no in-flight state), flush=0, freeze=hold, occupancy=0, core_rst=1.
- A branch at BR_DEPTH with br_taken=0 simply advances; the issue stall ends the following cycle.

## Structure
- Shared package rt_pipe_pkg: stage_ctl_t struct {v, wr_en, wr, io_wr, br}, default DEPTH/IO_DEPTH/BR_DEPTH constants, and a zero-bubble constant.
- One sub-module, pipe_stage_reg: a single stage register with hold/flush/bubble inputs, instantiated IO_DEPTH times via generate.
- Hazard compare and popcount stay in the top.

## Test plan
- Write r3 issued at t0, read r3 at t1 (DEPTH=5) -> hazard=1 for cycles t1..t5, accepted at t6, occupancy peaks at 5.
- IO write at t0, IO read at t1 (IO_DEPTH=7) -> hazard for 7 cycles; a register read of an unrelated register in the same window is also blocked.
- Branch at t0 with br_taken=1 at t4 -> flush=1 in cycle t4 only; stages 1..4 are invalid afterwards; the next issue is accepted at t5.
- hold=1 for 3 cycles while a producer is at stage 2 -> stage contents unchanged, hazard stays 1, and the dependent issue is accepted 3 cycles later than in the no-hold case.
- n_reset low for 2 cycles with occupancy=6 -> occupancy=0 and hazard=0 after the first edge; core_rst is high through the first high-n_reset edge, then 0.
- halt=1 with an empty pipe -> hazard=1 and no accepts; releasing halt gives an accept in the same cycle.
